next_block_preview: RTL and testbench

NEXT_BLOCK_PREVIEW -- requirements
Module: next_block_preview

---
 rtl/tetris_vga_pkg.sv | 39 +++
 rtl/next_block_preview_if.sv | 33 +++
 rtl/tetris_sprites.sv | 46 ++++
 rtl/next_block_preview.sv | 171 +++++++++++++++++
 tb/tb_next_block_preview.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_vga_pkg.sv
// -----------------------------------------------------------------------------
// tetris_vga_pkg
// Shared definitions for the Tetris VGA blocks: the block-code enum, the
// per-block colour table, the preview border colour and the sprite size.
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_vga_pkg;

  // Block codes as written by the CPU; BLK_NONE draws nothing.
  typedef enum logic [2:0] {
    BLK_I    = 3'd0,
    BLK_L    = 3'd1,
    BLK_J    = 3'd2,
    BLK_O    = 3'd3,
    BLK_S    = 3'd4,
    BLK_T    = 3'd5,
    BLK_Z    = 3'd6,
    BLK_NONE = 3'd7
  } blk_t;

  // Sprites are SPRITE_DIM x SPRITE_DIM sprite pixels.
  localparam int SPRITE_DIM = 8;

  // 12-bit RGB (4:4:4) colour per block code, indexed by blk_t.
  localparam logic [11:0] COLOR_LUT [0:7] = '{
    12'h0FF,  // I cyan
    12'hF80,  // L orange
    12'h00F,  // J blue
    12'hFF0,  // O yellow
    12'h0F0,  // S green
    12'hA0F,  // T purple
    12'hF00,  // Z red
    12'h000   // none
  };

  // Colour of the optional 1-pixel ring around the preview window.
  localparam logic [11:0] BORDER_RGB = 12'hFFF;

endpackage

// File: rtl/next_block_preview_if.sv
// -----------------------------------------------------------------------------
// next_block_preview_if
// Bundles the pixel stream, the CPU next-block write port and the preview
// pixel outputs.
//   pix_x, pix_y   : current pixel column/row from the VGA timing generator
//   video_on       : current pixel is visible
//   frame_start    : one-cycle pulse at the start of each frame
//   next_block_wr  : CPU write strobe for the next-block code
//   next_block_din : block code to write (blk_t encoding)
//   preview_hit    : delayed pixel is a lit preview pixel
//   preview_rgb    : colour of the delayed pixel, 0 when not hit
// Modports: master drives the stream/writes, slave is the preview block.
// -----------------------------------------------------------------------------
interface next_block_preview_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        video_on;
  logic        frame_start;
  logic        next_block_wr;
  logic [2:0]  next_block_din;
  logic        preview_hit;
  logic [11:0] preview_rgb;

  modport master (
    output pix_x, pix_y, video_on, frame_start, next_block_wr, next_block_din,
    input  preview_hit, preview_rgb
  );

  modport slave (
    input  pix_x, pix_y, video_on, frame_start, next_block_wr, next_block_din,
    output preview_hit, preview_rgb
  );
endinterface

// File: rtl/tetris_sprites.sv
// -----------------------------------------------------------------------------
// tetris_sprites
// Combinational 8x8 sprite row ROM. Each tetromino cell is 2x2 sprite
// pixels; all shapes occupy rows 2..5, the other rows are blank. Bit 7 of
// the returned row is the leftmost pixel.
//   blk  : block code (BLK_NONE returns all zeros)
//   row  : sprite row 0..7
//   bits : 8 pixels of that row, MSB = column 0
// -----------------------------------------------------------------------------
module tetris_sprites
  import tetris_vga_pkg::*;
(
  input  blk_t       blk,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  logic [7:0] upper;  // pattern for rows 2-3
  logic [7:0] lower;  // pattern for rows 4-5

  // Per-shape upper and lower cell rows.
  always_comb begin
    upper = 8'h00;
    lower = 8'h00;
    case (blk)
      BLK_I:   begin upper = 8'h00; lower = 8'hFF; end
      BLK_L:   begin upper = 8'h06; lower = 8'h7E; end
      BLK_J:   begin upper = 8'h60; lower = 8'h7E; end
      BLK_O:   begin upper = 8'h3C; lower = 8'h3C; end
      BLK_S:   begin upper = 8'h1E; lower = 8'h78; end
      BLK_T:   begin upper = 8'h7E; lower = 8'h18; end
      BLK_Z:   begin upper = 8'h78; lower = 8'h1E; end
      default: begin upper = 8'h00; lower = 8'h00; end
    endcase
  end

  // Rows 2-3 share row[2:1]=01, rows 4-5 share row[2:1]=10.
  always_comb begin
    case (row[2:1])
      2'b01:   bits = upper;
      2'b10:   bits = lower;
      default: bits = 8'h00;
    endcase
  end

endmodule

// File: rtl/next_block_preview.sv
// -----------------------------------------------------------------------------
// next_block_preview
// Draws the "next block" sprite in a fixed window of the VGA frame. The CPU
// writes a pending block code at any time; it becomes the displayed code at
// the next frame_start so the preview never tears. Pixels pass a 2-stage
// pipeline: the outputs for the pixel sampled in cycle t are registered and
// valid in cycle t+2. The pipeline never stalls.
// Parameters: ORIGIN_X/ORIGIN_Y window top-left, SCALE_LOG2 magnification.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : next_block_preview_if.slave (pixel stream, CPU write, outputs)
// Optional feature: define PREVIEW_BORDER_EN to draw a 1-pixel ring of
// BORDER_RGB around the window.
// -----------------------------------------------------------------------------
module next_block_preview
  import tetris_vga_pkg::*;
#(
  parameter int ORIGIN_X   = 520,
  parameter int ORIGIN_Y   = 80,
  parameter int SCALE_LOG2 = 3
) (
  input  logic clk,
  input  logic rst,
  next_block_preview_if.slave bus
);

  localparam int          WIN   = SPRITE_DIM << SCALE_LOG2;
  localparam logic [10:0] OX    = 11'(ORIGIN_X);
  localparam logic [10:0] OY    = 11'(ORIGIN_Y);
  localparam logic [10:0] WIN11 = 11'(WIN);

  blk_t pending_blk;
  blk_t active_blk;

  // Stage-1 combinational
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_win;
  logic [2:0]  col;
  logic [2:0]  row;

  // Stage-1 registers
  logic        s1_in_win;
  logic [2:0]  s1_col;
  logic [2:0]  s1_row;
  blk_t        s1_blk;

  // Stage-2 combinational and output registers
  logic [7:0]  rom_row;
  logic        lit;
  logic        next_hit;
  logic [11:0] next_rgb;
  logic        out_hit;
  logic [11:0] out_rgb;

`ifdef PREVIEW_BORDER_EN
  logic x_edge;
  logic y_edge;
  logic x_span;
  logic y_span;
  logic border;
  logic s1_border;
`endif

  // Block code registers; a write coinciding with frame_start goes straight to display.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_blk <= BLK_NONE;
      active_blk  <= BLK_NONE;
    end else begin
      if (bus.next_block_wr) begin
        pending_blk <= blk_t'(bus.next_block_din);
      end
      if (bus.frame_start) begin
        active_blk <= bus.next_block_wr ? blk_t'(bus.next_block_din) : pending_blk;
      end
    end
  end

  // Window-relative offsets; below-origin pixels wrap to large values in 11 bits.
  always_comb begin
    dx     = {1'b0, bus.pix_x} - OX;
    dy     = {1'b0, bus.pix_y} - OY;
    in_win = bus.video_on
             && ({1'b0, bus.pix_x} >= OX) && ({1'b0, bus.pix_y} >= OY)
             && (dx < WIN11) && (dy < WIN11);
    col    = dx[SCALE_LOG2+2:SCALE_LOG2];
    row    = dy[SCALE_LOG2+2:SCALE_LOG2];
  end

`ifdef PREVIEW_BORDER_EN
  // Ring detection: offset -1 (all ones) or WIN on one axis, within -1..WIN on the other.
  always_comb begin
    x_edge = (dx == 11'h7FF) || (dx == WIN11);
    y_edge = (dy == 11'h7FF) || (dy == WIN11);
    x_span = (dx == 11'h7FF) || (dx <= WIN11);
    y_span = (dy == 11'h7FF) || (dy <= WIN11);
    border = bus.video_on && ((x_edge && y_span) || (y_edge && x_span));
  end
`endif

  // Stage-1 pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_in_win <= 1'b0;
      s1_col    <= 3'd0;
      s1_row    <= 3'd0;
      s1_blk    <= BLK_NONE;
`ifdef PREVIEW_BORDER_EN
      s1_border <= 1'b0;
`endif
    end else begin
      s1_in_win <= in_win;
      s1_col    <= col;
      s1_row    <= row;
      s1_blk    <= active_blk;
`ifdef PREVIEW_BORDER_EN
      s1_border <= border;
`endif
    end
  end

  tetris_sprites u_sprites (
    .blk  (s1_blk),
    .row  (s1_row),
    .bits (rom_row)
  );

  // Pixel decision; the ROM row is consumed here and captured into the stage-2 output register.
  always_comb begin
    lit      = rom_row[3'd7 - s1_col];
    next_hit = 1'b0;
    next_rgb = 12'h000;
`ifdef PREVIEW_BORDER_EN
    if (s1_border) begin
      next_hit = 1'b1;
      next_rgb = BORDER_RGB;
    end else if (s1_in_win && lit) begin
      next_hit = 1'b1;
      next_rgb = COLOR_LUT[s1_blk];
    end else begin
      next_hit = 1'b0;
      next_rgb = 12'h000;
    end
`else
    if (s1_in_win && lit) begin
      next_hit = 1'b1;
      next_rgb = COLOR_LUT[s1_blk];
    end else begin
      next_hit = 1'b0;
      next_rgb = 12'h000;
    end
`endif
  end

  // Stage-2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_hit <= 1'b0;
      out_rgb <= 12'h000;
    end else begin
      out_hit <= next_hit;
      out_rgb <= next_rgb;
    end
  end

  assign bus.preview_hit = out_hit;
  assign bus.preview_rgb = out_rgb;

endmodule

// File: tb/tb_next_block_preview.sv
// -----------------------------------------------------------------------------
// tb_next_block_preview
// Directed self-checking bench for next_block_preview with default
// parameters (window 520..583 x 80..143, 8x8 screen pixels per sprite pixel).
// -----------------------------------------------------------------------------
module tb_next_block_preview;

  localparam logic [9:0] OX = 10'd520;
  localparam logic [9:0] OY = 10'd80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  next_block_preview_if bif ();

  next_block_preview dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Present one pixel; outputs for it are valid after two rising edges.
  task automatic scan(input logic [9:0] x, input logic [9:0] y, input logic von);
    @(negedge clk);
    bif.pix_x    = x;
    bif.pix_y    = y;
    bif.video_on = von;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] d);
    @(negedge clk);
    bif.next_block_wr  = 1'b1;
    bif.next_block_din = d;
    @(posedge clk);
    #1;
    bif.next_block_wr  = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bif.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bif.frame_start = 1'b0;
  endtask

  task automatic check_px(input string name, input logic exp_hit, input logic [11:0] exp_rgb);
    tests_run++;
    if (bif.preview_hit !== exp_hit || bif.preview_rgb !== exp_rgb) begin
      tests_failed++;
      $display("FAIL %s: hit=%0b rgb=%03h, expected hit=%0b rgb=%03h",
               name, bif.preview_hit, bif.preview_rgb, exp_hit, exp_rgb);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if (bif.preview_hit !== 1'b0 || bif.preview_rgb !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_out: hit=%0b rgb=%03h, expected 0/000", bif.preview_hit, bif.preview_rgb);
    end
    tests_run++;
    if (3'(dut.active_blk) !== 3'd7 || 3'(dut.pending_blk) !== 3'd7) begin
      tests_failed++;
      $display("FAIL reset_blk: active=%0d pending=%0d, expected 7/7", dut.active_blk, dut.pending_blk);
    end
    @(negedge clk);
    rst = 1'b0;
    scan(OX + 10'd16, OY + 10'd16, 1'b1);
    check_px("reset_blank", 1'b0, 12'h000);
    // A write alone is not displayed until a frame_start.
    cpu_write(3'd3);
    scan(OX + 10'd16, OY + 10'd16, 1'b1);
    check_px("write_no_frame", 1'b0, 12'h000);
  endtask

  task automatic test_o_block();
    pulse_frame();
    scan(OX + 10'd16, OY + 10'd16, 1'b1);
    check_px("o_lit", 1'b1, 12'hFF0);
    scan(OX, OY, 1'b1);
    check_px("o_corner", 1'b0, 12'h000);
    scan(OX + 10'd40, OY + 10'd40, 1'b1);
    check_px("o_col5_row5", 1'b1, 12'hFF0);
    scan(OX + 10'd48, OY + 10'd16, 1'b1);
    check_px("o_col6", 1'b0, 12'h000);
  endtask

  task automatic test_tear_free();
    cpu_write(3'd5);
    pulse_frame();
    scan(OX + 10'd8, OY + 10'd16, 1'b1);
    check_px("t_shown", 1'b1, 12'hA0F);
    cpu_write(3'd6);
    scan(OX + 10'd8, OY + 10'd16, 1'b1);
    check_px("t_mid_frame", 1'b1, 12'hA0F);
    scan(OX + 10'd24, OY + 10'd32, 1'b1);
    check_px("t_stem", 1'b1, 12'hA0F);
    pulse_frame();
    scan(OX + 10'd8, OY + 10'd16, 1'b1);
    check_px("z_shown", 1'b1, 12'hF00);
    scan(OX + 10'd48, OY + 10'd16, 1'b1);
    check_px("z_gap", 1'b0, 12'h000);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bif.next_block_wr  = 1'b1;
    bif.next_block_din = 3'd0;
    bif.frame_start    = 1'b1;
    @(posedge clk);
    #1;
    bif.next_block_wr  = 1'b0;
    bif.frame_start    = 1'b0;
    tests_run++;
    if (3'(dut.active_blk) !== 3'd0) begin
      tests_failed++;
      $display("FAIL simul_active: active=%0d, expected 0", dut.active_blk);
    end
    for (int r = 4; r <= 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        scan(OX + 10'(c * 8 + 3), OY + 10'(r * 8 + 7), 1'b1);
        check_px($sformatf("i_row%0d_col%0d", r, c), 1'b1, 12'h0FF);
      end
    end
    scan(OX + 10'd8, OY + 10'd31, 1'b1);
    check_px("i_row3", 1'b0, 12'h000);
  endtask

  task automatic test_edges();
    scan(OX + 10'd63, OY + 10'd32, 1'b1);
    check_px("edge_x63", 1'b1, 12'h0FF);
    scan(OX + 10'd64, OY + 10'd32, 1'b1);
    check_px("edge_x64", 1'b0, 12'h000);
    scan(OX + 10'd8, OY + 10'd64, 1'b1);
    check_px("edge_y64", 1'b0, 12'h000);
    scan(OX + 10'd8, OY + 10'd32, 1'b0);
    check_px("video_off", 1'b0, 12'h000);
    scan(OX - 10'd8, OY + 10'd32, 1'b1);
    check_px("left_of_win", 1'b0, 12'h000);
  endtask

  task automatic test_border();
`ifdef PREVIEW_BORDER_EN
    scan(OX - 10'd1, OY + 10'd5, 1'b1);
    check_px("border_left", 1'b1, 12'hFFF);
    scan(OX + 10'd64, OY + 10'd64, 1'b1);
    check_px("border_corner", 1'b1, 12'hFFF);
    scan(OX - 10'd2, OY + 10'd5, 1'b1);
    check_px("border_outside", 1'b0, 12'h000);
`else
    scan(OX - 10'd1, OY + 10'd5, 1'b1);
    check_px("no_border_left", 1'b0, 12'h000);
    scan(OX + 10'd64, OY + 10'd64, 1'b1);
    check_px("no_border_corner", 1'b0, 12'h000);
`endif
  endtask

  // One new pixel per cycle: output after edge i reflects the input of cycle i-1.
  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b0100_1101;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        bif.pix_x    = OX + 10'd8;
        bif.pix_y    = OY + 10'd32;
        bif.video_on = pat[i];
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        check_px($sformatf("stream_%0d", i - 1), pat[i-1], pat[i-1] ? 12'h0FF : 12'h000);
      end
    end
  endtask

  task automatic test_reset_mid();
    scan(OX + 10'd8, OY + 10'd32, 1'b1);
    check_px("pre_reset_lit", 1'b1, 12'h0FF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_px("reset_mid_out", 1'b0, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_px("after_reset_blank", 1'b0, 12'h000);
    cpu_write(3'd4);
    scan(OX + 10'd8, OY + 10'd32, 1'b1);
    check_px("after_reset_write", 1'b0, 12'h000);
    pulse_frame();
    scan(OX + 10'd8, OY + 10'd32, 1'b1);
    check_px("s_after_frame", 1'b1, 12'h0F0);
    scan(OX, OY + 10'd32, 1'b1);
    check_px("s_col0_row4", 1'b0, 12'h000);
  endtask

  initial begin
    bif.pix_x          = 10'd0;
    bif.pix_y          = 10'd0;
    bif.video_on       = 1'b0;
    bif.frame_start    = 1'b0;
    bif.next_block_wr  = 1'b0;
    bif.next_block_din = 3'd0;
    test_reset();
    test_o_block();
    test_tear_free();
    test_simultaneous();
    test_edges();
    test_border();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
